spi_cmd_slave: RTL and testbench
================================

SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

Interface
REQ-001 Parameter WORD_W, default 16, SPI word width in bits (8..32).
REQ-002 Parameter ADDR_W, default 8, register address width.
REQ-003 Parameter NUM_FIFO, default 2, number of readable FIFO channels (1..8).
REQ-004 Port CLK  in  1  system clock (64 MHz); single clock domain.
REQ-005 Port RESET  in  1  reset, synchronous to CLK, active-high.
REQ-006 Ports spi_clk, spi_csn, spi_mosi  in  1 each  raw SPI pins, asynchronous to CLK, mode 3 (SCK idles high).
REQ-007 Port spi_miso  out  1  serial read data, MSB first.
REQ-008 Ports reg_wr_en out 1, reg_addr out ADDR_W, reg_wdata out WORD_W  register write strobe, address and data.
REQ-009 Ports reg_rd_en out 1, reg_rdata in WORD_W  register read strobe; data valid exactly 1 CLK after strobe.
REQ-010 Ports fifo_rd_en out NUM_FIFO (one-hot), fifo_rdata in NUM_FIFO*WORD_W, fifo_empty in NUM_FIFO  FIFO pop interface; data valid 1 CLK after pop.
REQ-011 Ports sys_enable out 1, cmd_err out 1, fifo_underrun out NUM_FIFO  machine enable, sticky bad-opcode flag, sticky per-channel underrun flag.

Function
REQ-012 spi_clk, spi_csn and spi_mosi shall each pass a 2-FF synchroniser; SCK rise/fall shall be single-CLK pulses from one further register (3 CLK detect latency).
REQ-013 The block shall require SCK high and low phases of at least 4 CLK; shorter phases are out of scope.
REQ-014 MOSI shall be sampled on each detected SCK rise; a word completes on the WORD_W-th rise since csn fell or since the previous word.
REQ-015 A csn rise shall abort the transaction: partial word discarded, state returns to IDLE, no strobe issued for it.
REQ-016 States: IDLE, CMD, ADDR, WDATA, RDATA, FDATA, DISCARD; csn fall enters CMD from any state.
REQ-017 The command word's top 4 bits are the opcode: 0x1 MEM_WR, 0x2 MEM_RD, 0x3 EN_SET, 0x4 EN_CLR, 0x5 FIFO_RD (channel = low 3 bits).
REQ-018 MEM_WR/MEM_RD shall go CMD->ADDR; the address word's low ADDR_W bits load the address counter; then WDATA or RDATA.
REQ-019 In WDATA each completed word shall produce one reg_wr_en pulse 1 CLK after completion with current address; address then increments.
REQ-020 The address counter shall wrap from 2^ADDR_W-1 to 0.
REQ-021 In RDATA, reg_rd_en shall pulse 1 CLK after each word boundary (including the address word); reg_rdata shall load the MISO shift register before the next SCK fall; address then increments.
REQ-022 EN_SET/EN_CLR shall set/clear sys_enable 1 CLK after command completion, then enter DISCARD.
REQ-023 FIFO_RD shall enter FDATA and pop the selected channel once per word boundary, prefetching as in REQ-021; if fifo_empty, no pop, the word shifts out as 0 and fifo_underrun[ch] sets.
REQ-024 An undefined opcode or channel >= NUM_FIFO shall set cmd_err and enter DISCARD (words ignored, MISO 0).
REQ-025 spi_miso shall update on each detected SCK fall; it shall be 0 in IDLE, CMD, ADDR, DISCARD.
REQ-026 A word completion coinciding with a csn rise shall be treated as complete (strobe issued), then IDLE.

Reset
REQ-027 RESET shall force IDLE, all strobes 0, spi_miso 0, sys_enable 0, cmd_err 0, fifo_underrun 0, address counter 0, shift registers 0, synchroniser stages to idle levels (SCK 1, csn 1).
REQ-028 RESET mid-transaction shall abort it with no strobe; the next csn fall starts cleanly.

Structure
REQ-029 Opcode constants and their field positions shall live in the shared Defines package alongside the existing command codes.
REQ-030 One sub-module, spi_sync_edge, shall hold the 2-FF synchroniser plus rise/fall detector, instantiated for SCK and csn.

Verification
REQ-031 MEM_WR 0x1000, addr 4, data 0x1234, 0xBEEF -> reg_wr_en pulses at addr 4 (0x1234) and addr 5 (0xBEEF), no others.
REQ-032 MEM_RD 0x2000, addr 0xFF with reg model returning addr*3, three data words -> MISO words 0x02FD, 0x0000, 0x0003 (wrap to 0).
REQ-033 EN_SET 0x3000 then EN_CLR 0x4000 in separate csn frames -> sys_enable 1 then 0; extra words after EN_SET ignored.
REQ-034 FIFO_RD ch1 (0x5001), FIFO holding 0xAAAA only, two data words -> MISO 0xAAAA then 0x0000, one pop, fifo_underrun[1]=1.
REQ-035 Opcode 0xF, and FIFO_RD ch 7 with NUM_FIFO=2 -> cmd_err=1, no strobes, MISO 0.
REQ-036 csn rise after 9 bits of a WDATA word, and RESET asserted mid-word -> no reg_wr_en; following MEM_WR frame writes correctly.

Source files
------------

// File: rtl/spi_cmd_slave_pkg.sv
// Shared definitions for the SPI command slave: opcodes, command field layout,
// protocol states and the MISO prefetch source selector.
package spi_cmd_slave_pkg;

    // The opcode sits in the top OPCODE_W bits of the command word.
    // The FIFO channel sits in the low CHAN_W bits.
    localparam int OPCODE_W = 4;
    localparam int CHAN_W   = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_MEM_WR  = 4'h1,
        OP_MEM_RD  = 4'h2,
        OP_EN_SET  = 4'h3,
        OP_EN_CLR  = 4'h4,
        OP_FIFO_RD = 4'h5
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_FDATA,
        ST_DISCARD
    } state_e;

    // Where the next outgoing MISO word comes from.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_REG,
        SRC_FIFO,
        SRC_ZERO
    } fetch_src_e;

    function automatic logic is_data_state(input state_e s);
        return (s == ST_RDATA) || (s == ST_FDATA);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin followed by a registered
// edge detector producing single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_1 <= IDLE_VAL;
            sync_2 <= IDLE_VAL;
            sync_3 <= IDLE_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            rise   <= sync_2 & ~sync_3;
            fall   <= ~sync_2 & sync_3;
        end
    end

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-3 command slave: decodes command/address/data words into register
// write/read strobes, FIFO pops and an enable bit, and streams read data on MISO.
module spi_cmd_slave
    import spi_cmd_slave_pkg::*;
#(
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int NUM_FIFO = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       spi_clk,
    input  logic                       spi_csn,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic                       reg_wr_en,
    output logic [ADDR_W-1:0]          reg_addr,
    output logic [WORD_W-1:0]          reg_wdata,
    output logic                       reg_rd_en,
    input  logic [WORD_W-1:0]          reg_rdata,
    output logic [NUM_FIFO-1:0]        fifo_rd_en,
    input  logic [NUM_FIFO*WORD_W-1:0] fifo_rdata,
    input  logic [NUM_FIFO-1:0]        fifo_empty,
    output logic                       sys_enable,
    output logic                       cmd_err,
    output logic [NUM_FIFO-1:0]        fifo_underrun
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WORD_W - 1);

    logic sck_rise;
    logic sck_fall;
    logic csn_rise;
    logic csn_fall;
    logic mosi_s1;
    logic mosi_s2;

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sck_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (spi_clk),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_csn_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (spi_csn),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    // MOSI only needs a level; it is stable for several CLK around each SCK rise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    state_e                 state;
    state_e                 state_nx;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WORD_W-1:0]      shift_in;
    logic [WORD_W-1:0]      rx_word;
    logic                   word_done;
    logic [WORD_W-1:0]      tx_shift;
    logic [ADDR_W-1:0]      addr_q;
    logic                   rd_mode;
    logic [CHAN_W-1:0]      fifo_ch;
    logic [OPCODE_W-1:0]    cmd_opcode;
    logic [CHAN_W-1:0]      cmd_chan;
    logic [CHAN_W-1:0]      chan_sel;
    logic                   sel_empty;
    logic [WORD_W-1:0]      fifo_sel_data;
    logic [WORD_W-1:0]      load_data;
    fetch_src_e             fetch_nx;
    fetch_src_e             fetch_q;
    fetch_src_e             load_q;
    logic                   wr_fire;
    logic                   addr_load;
    logic                   cmd_load;
    logic                   en_set;
    logic                   en_clr;
    logic                   err_set;

    assign rx_word    = {shift_in[WORD_W-2:0], mosi_s2};
    assign word_done  = sck_rise && (state != ST_IDLE) && (bit_cnt == BIT_LAST);
    assign cmd_opcode = rx_word[WORD_W-1 -: OPCODE_W];
    assign cmd_chan   = rx_word[CHAN_W-1:0];
    assign reg_addr   = addr_q;

    // The command word itself already prefetches, before fifo_ch is latched.
    assign chan_sel = (state == ST_CMD) ? cmd_chan : fifo_ch;

    always_comb begin
        sel_empty     = 1'b1;
        fifo_sel_data = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            if (chan_sel == CHAN_W'(i)) begin
                sel_empty = fifo_empty[i];
            end
            if (fifo_ch == CHAN_W'(i)) begin
                fifo_sel_data = fifo_rdata[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        unique case (load_q)
            SRC_REG:  load_data = reg_rdata;
            SRC_FIFO: load_data = fifo_sel_data;
            default:  load_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default before any branch so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        fetch_nx  = SRC_NONE;
        wr_fire   = 1'b0;
        addr_load = 1'b0;
        cmd_load  = 1'b0;
        en_set    = 1'b0;
        en_clr    = 1'b0;
        err_set   = 1'b0;
        if (word_done) begin
            unique case (state)
                ST_CMD: begin
                    cmd_load = 1'b1;
                    case (opcode_e'(cmd_opcode))
                        OP_MEM_WR, OP_MEM_RD: state_nx = ST_ADDR;
                        OP_EN_SET: begin
                            en_set   = 1'b1;
                            state_nx = ST_DISCARD;
                        end
                        OP_EN_CLR: begin
                            en_clr   = 1'b1;
                            state_nx = ST_DISCARD;
                        end
                        OP_FIFO_RD: begin
                            if (int'(cmd_chan) < NUM_FIFO) begin
                                state_nx = ST_FDATA;
                                fetch_nx = sel_empty ? SRC_ZERO : SRC_FIFO;
                            end else begin
                                err_set  = 1'b1;
                                state_nx = ST_DISCARD;
                            end
                        end
                        default: begin
                            err_set  = 1'b1;
                            state_nx = ST_DISCARD;
                        end
                    endcase
                end
                ST_ADDR: begin
                    addr_load = 1'b1;
                    if (rd_mode) begin
                        state_nx = ST_RDATA;
                        fetch_nx = SRC_REG;
                    end else begin
                        state_nx = ST_WDATA;
                    end
                end
                ST_WDATA: wr_fire  = 1'b1;
                ST_RDATA: fetch_nx = SRC_REG;
                ST_FDATA: fetch_nx = sel_empty ? SRC_ZERO : SRC_FIFO;
                default: ;
            endcase
        end
        // A word finishing together with csn rising still counts; the frame ends after it.
        if (csn_rise) begin
            state_nx = ST_IDLE;
        end
        if (csn_fall) begin
            state_nx = ST_CMD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt  <= '0;
            shift_in <= '0;
        end else if (csn_fall || csn_rise) begin
            bit_cnt  <= '0;
            shift_in <= '0;
        end else if (sck_rise && (state != ST_IDLE)) begin
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            shift_in <= rx_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_mode <= 1'b0;
            fifo_ch <= '0;
        end else if (cmd_load) begin
            rd_mode <= (cmd_opcode == OP_MEM_RD);
            fifo_ch <= cmd_chan;
        end
    end

    // The address advances during the strobe cycle so the strobe sees the current address.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q <= '0;
        end else if (addr_load) begin
            addr_q <= rx_word[ADDR_W-1:0];
        end else if (reg_wr_en || reg_rd_en) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_wr_en     <= 1'b0;
            reg_wdata     <= '0;
            reg_rd_en     <= 1'b0;
            fifo_rd_en    <= '0;
            fifo_underrun <= '0;
            fetch_q       <= SRC_NONE;
            load_q        <= SRC_NONE;
            sys_enable    <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            reg_wr_en <= wr_fire;
            if (wr_fire) begin
                reg_wdata <= rx_word;
            end
            reg_rd_en <= (fetch_nx == SRC_REG);
            for (int i = 0; i < NUM_FIFO; i++) begin
                fifo_rd_en[i] <= (fetch_nx == SRC_FIFO) && (chan_sel == CHAN_W'(i));
                if ((fetch_nx == SRC_ZERO) && (chan_sel == CHAN_W'(i))) begin
                    fifo_underrun[i] <= 1'b1;
                end
            end
            fetch_q <= fetch_nx;
            load_q  <= fetch_q;
            if (en_set) begin
                sys_enable <= 1'b1;
            end else if (en_clr) begin
                sys_enable <= 1'b0;
            end
            if (err_set) begin
                cmd_err <= 1'b1;
            end
        end
    end

    // Fetched data lands two CLK after the word boundary, well before the next SCK fall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_shift <= '0;
            spi_miso <= 1'b0;
        end else begin
            if (load_q != SRC_NONE) begin
                tx_shift <= load_data;
            end else if (sck_fall && is_data_state(state)) begin
                tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
            end
            if (!is_data_state(state)) begin
                spi_miso <= 1'b0;
            end else if (sck_fall) begin
                spi_miso <= tx_shift[WORD_W-1];
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: bit-banged mode-3 SPI master, register and
// FIFO models, and queue scoreboards for register writes and MISO words.
module tb_spi_cmd_slave;

    localparam int W    = 16;
    localparam int AW   = 8;
    localparam int NF   = 2;
    localparam int HALF = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              spi_clk;
    logic              spi_csn;
    logic              spi_mosi;
    logic              spi_miso;
    logic              reg_wr_en;
    logic [AW-1:0]     reg_addr;
    logic [W-1:0]      reg_wdata;
    logic              reg_rd_en;
    logic [W-1:0]      reg_rdata;
    logic [NF-1:0]     fifo_rd_en;
    logic [NF*W-1:0]   fifo_rdata;
    logic [NF-1:0]     fifo_empty;
    logic              sys_enable;
    logic              cmd_err;
    logic [NF-1:0]     fifo_underrun;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int pop_cnt  = 0;

    wr_t           wr_q[$];
    logic [W-1:0]  miso_q[$];

    logic [W-1:0]  fmem [NF][4];
    int            fwr [NF];
    int            frd [NF];

    spi_cmd_slave #(.WORD_W(W), .ADDR_W(AW), .NUM_FIFO(NF)) dut (
        .CLK           (clk),
        .RESET         (reset),
        .spi_clk       (spi_clk),
        .spi_csn       (spi_csn),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .reg_wr_en     (reg_wr_en),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rd_en     (reg_rd_en),
        .reg_rdata     (reg_rdata),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rdata    (fifo_rdata),
        .fifo_empty    (fifo_empty),
        .sys_enable    (sys_enable),
        .cmd_err       (cmd_err),
        .fifo_underrun (fifo_underrun)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register model: data valid one CLK after the read strobe.
    always @(posedge clk) begin
        if (reset) begin
            reg_rdata <= '0;
        end else if (reg_rd_en) begin
            reg_rdata <= W'(reg_addr * 3);
        end
    end

    // FIFO model, one small ring per channel.
    initial begin
        for (int i = 0; i < NF; i++) begin
            fwr[i] = 0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            fifo_rdata <= '0;
            for (int i = 0; i < NF; i++) begin
                frd[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (fifo_rd_en[i]) begin
                    fifo_rdata[i*W +: W] <= fmem[i][frd[i] % 4];
                    frd[i] <= frd[i] + 1;
                end
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        for (int i = 0; i < NF; i++) begin
            fifo_empty[i] = (fwr[i] == frd[i]);
        end
    end

    // Output monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(reg_wr_en), 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(e.addr));
                check("wr_data", 32'(reg_wdata), 32'(e.data));
            end
        end
        if (reg_rd_en) begin
            rd_cnt++;
        end
        if ((fifo_rd_en & fifo_empty) != '0) begin
            check("pop_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        end
        pop_cnt += $countones(fifo_rd_en);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic xfer(input logic [W-1:0] tx, input int nbits, input bit csn_on_last,
                        output logic [W-1:0] rx);
        rx = '0;
        for (int i = W - 1; i > W - 1 - nbits; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = tx[i];
            cyc(HALF);
            rx[i]   = spi_miso;
            spi_clk = 1'b1;
            if (csn_on_last && i == 0) begin
                spi_csn = 1'b1;
            end
            cyc(HALF);
        end
    endtask

    task automatic send(input string tag, input logic [W-1:0] tx, input logic [W-1:0] exp_miso);
        logic [W-1:0] rx;
        miso_q.push_back(exp_miso);
        xfer(tx, W, 1'b0, rx);
        check(tag, 32'(rx), 32'(miso_q.pop_front()));
    endtask

    task automatic begin_frame();
        spi_csn = 1'b0;
        cyc(8);
    endtask

    task automatic end_frame();
        cyc(4);
        spi_csn = 1'b1;
        cyc(12);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
    endtask

    initial begin
        logic [W-1:0]  rx;
        logic [AW-1:0] a;
        int wr_base;
        int rd_base;
        int pop_base;

        spi_clk  = 1'b1;
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        reset    = 1'b1;
        cyc(5);
        reset = 1'b0;
        cyc(2);

        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_sys_enable", 32'(sys_enable), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_underrun", 32'(fifo_underrun), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);

        // Burst write with auto-increment.
        wr_base = wr_cnt;
        wr_q.push_back(wr_t'{addr: 8'h04, data: 16'h1234});
        wr_q.push_back(wr_t'{addr: 8'h05, data: 16'hBEEF});
        begin_frame();
        send("wr_cmd_miso", 16'h1000, 16'h0000);
        send("wr_addr_miso", 16'h0004, 16'h0000);
        xfer(16'h1234, W, 1'b0, rx);
        xfer(16'hBEEF, W, 1'b0, rx);
        end_frame();
        check("wr_count", 32'(wr_cnt - wr_base), 32'd2);
        check("wr_drained", 32'(wr_q.size()), 32'd0);

        // Burst read across the address wrap.
        rd_base = rd_cnt;
        begin_frame();
        send("rd_cmd_miso", 16'h2000, 16'h0000);
        send("rd_addr_miso", 16'h00FF, 16'h0000);
        a = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            send("rd_data_miso", 16'h0000, W'(a * 3));
            a = a + 8'd1;
        end
        end_frame();
        check("rd_count", 32'(rd_cnt - rd_base), 32'd4);
        check("idle_miso", 32'(spi_miso), 32'd0);

        // Enable set with trailing words ignored, then clear.
        wr_base = wr_cnt;
        begin_frame();
        send("en_cmd_miso", 16'h3000, 16'h0000);
        send("discard_miso", 16'h1234, 16'h0000);
        send("discard_miso", 16'hFFFF, 16'h0000);
        end_frame();
        check("en_set", 32'(sys_enable), 32'd1);
        check("discard_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        begin_frame();
        send("en_clr_miso", 16'h4000, 16'h0000);
        end_frame();
        check("en_clr", 32'(sys_enable), 32'd0);
        check("en_no_err", 32'(cmd_err), 32'd0);

        // FIFO read: one real word, then underrun.
        fmem[1][fwr[1] % 4] = 16'hAAAA;
        fwr[1] = fwr[1] + 1;
        pop_base = pop_cnt;
        begin_frame();
        send("fifo_cmd_miso", 16'h5001, 16'h0000);
        send("fifo_word0", 16'h0000, 16'hAAAA);
        send("fifo_word1", 16'h0000, 16'h0000);
        end_frame();
        check("fifo_pops", 32'(pop_cnt - pop_base), 32'd1);
        check("fifo_underrun", 32'(fifo_underrun), 32'h2);
        check("fifo_no_err", 32'(cmd_err), 32'd0);

        // Undefined opcode.
        wr_base = wr_cnt; rd_base = rd_cnt; pop_base = pop_cnt;
        begin_frame();
        send("badop_cmd_miso", 16'hF000, 16'h0000);
        send("badop_word_miso", 16'h1111, 16'h0000);
        end_frame();
        check("badop_err", 32'(cmd_err), 32'd1);
        check("badop_strobes", 32'((wr_cnt - wr_base) + (rd_cnt - rd_base) + (pop_cnt - pop_base)), 32'd0);

        pulse_reset();
        check("rst2_cmd_err", 32'(cmd_err), 32'd0);
        check("rst2_underrun", 32'(fifo_underrun), 32'd0);

        // FIFO channel beyond NUM_FIFO.
        wr_base = wr_cnt; rd_base = rd_cnt; pop_base = pop_cnt;
        begin_frame();
        send("badch_cmd_miso", 16'h5007, 16'h0000);
        send("badch_word_miso", 16'h0000, 16'h0000);
        end_frame();
        check("badch_err", 32'(cmd_err), 32'd1);
        check("badch_strobes", 32'((wr_cnt - wr_base) + (rd_cnt - rd_base) + (pop_cnt - pop_base)), 32'd0);
        check("badch_underrun", 32'(fifo_underrun), 32'd0);

        // csn abort after 9 bits of a data word.
        wr_base = wr_cnt;
        begin_frame();
        xfer(16'h1000, W, 1'b0, rx);
        xfer(16'h0010, W, 1'b0, rx);
        xfer(16'hFFFF, 9, 1'b0, rx);
        end_frame();
        check("abort_no_wr", 32'(wr_cnt - wr_base), 32'd0);

        // Reset in the middle of a data word.
        begin_frame();
        xfer(16'h1000, W, 1'b0, rx);
        xfer(16'h0020, W, 1'b0, rx);
        xfer(16'hFFFF, 9, 1'b0, rx);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(4);
        end_frame();
        check("reset_no_wr", 32'(wr_cnt - wr_base), 32'd0);

        // Clean write after the aborts.
        wr_q.push_back(wr_t'{addr: 8'h30, data: 16'h5A5A});
        begin_frame();
        xfer(16'h1000, W, 1'b0, rx);
        xfer(16'h0030, W, 1'b0, rx);
        xfer(16'h5A5A, W, 1'b0, rx);
        end_frame();
        check("recover_wr_count", 32'(wr_cnt - wr_base), 32'd1);

        // Final rise of a word coinciding with csn rise still writes.
        wr_q.push_back(wr_t'{addr: 8'h40, data: 16'hC3C3});
        begin_frame();
        xfer(16'h1000, W, 1'b0, rx);
        xfer(16'h0040, W, 1'b0, rx);
        xfer(16'hC3C3, W, 1'b1, rx);
        cyc(12);
        check("coincide_wr_count", 32'(wr_cnt - wr_base), 32'd2);
        check("final_wr_drained", 32'(wr_q.size()), 32'd0);
        check("final_miso", 32'(spi_miso), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
